hex_display_scan: RTL and testbench

Parametrised multi-digit seven-segment scanner that replaces the single-byte hex output of the SoC top level. It accepts a DIGITS-nibble value and drives one time-multiplexed common segment bus plus per-digit enables. It adds tear-free double buffering, optional leading-zero blanking and a blinking error indication. It sits between the SoC status/debug register and the board display pins.

---
 rtl/hex_display_scan.sv | 151 +++++++++++++++
 tb/tb_hex_display_scan.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scan.sv
// rtl/hex_display_scan.sv - multiplexed seven-segment hex scanner with tear-free double buffering
module hex_display_scan #(
    parameter int DIGITS     = 4,
    parameter int CLK_DIV    = 1024,
    parameter int BLINK_DIV  = 64,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic [4*DIGITS-1:0]   i_value,
    input  logic                  i_load,
    input  logic                  i_error,
    input  logic                  i_blank_lz,
    output logic [6:0]            o_seg,
    output logic                  o_dp,
    output logic [DIGITS-1:0]     o_an,
    output logic                  o_frame
);
    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] INDEX_LAST = IW'(DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam bit            INV        = (ACTIVE_LOW != 0);

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   pending;
    logic                  pend_flag;
    logic [4*DIGITS-1:0]   display;
    logic                  err_flag;
    logic [BW-1:0]         blink_cnt;
    logic                  blink_phase;

    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [DIGITS-1:0]     an_q;
    logic                  frame_q;

    logic                  presc_tc;
    logic                  boundary;
    logic [3:0]            nib;
    logic                  upper_zero;
    logic [6:0]            seg_d;
    logic                  dp_d;
    logic [DIGITS-1:0]     an_d;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_to_seg = 7'h3F;
            4'h1: hex_to_seg = 7'h06;
            4'h2: hex_to_seg = 7'h5B;
            4'h3: hex_to_seg = 7'h4F;
            4'h4: hex_to_seg = 7'h66;
            4'h5: hex_to_seg = 7'h6D;
            4'h6: hex_to_seg = 7'h7D;
            4'h7: hex_to_seg = 7'h07;
            4'h8: hex_to_seg = 7'h7F;
            4'h9: hex_to_seg = 7'h6F;
            4'hA: hex_to_seg = 7'h77;
            4'hB: hex_to_seg = 7'h7C;
            4'hC: hex_to_seg = 7'h39;
            4'hD: hex_to_seg = 7'h5E;
            4'hE: hex_to_seg = 7'h79;
            default: hex_to_seg = 7'h71;
        endcase
    endfunction

    assign presc_tc = (presc == PRESC_LAST);
    assign boundary = presc_tc && (idx == INDEX_LAST);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            presc       <= '0;
            idx         <= '0;
            pending     <= '0;
            pend_flag   <= 1'b0;
            display     <= '0;
            err_flag    <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            presc <= presc_tc ? '0 : presc + PW'(1);
            if (presc_tc) begin
                idx <= boundary ? '0 : idx + IW'(1);
            end
            if (i_load) begin
                pending <= i_value;
            end
            // Display, error and blink state only move at the frame boundary so a frame is never torn.
            if (boundary) begin
                pend_flag <= 1'b0;
                if (i_load) begin
                    display <= i_value;
                end else if (pend_flag) begin
                    display <= pending;
                end
                err_flag <= i_error;
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end else if (i_load) begin
                pend_flag <= 1'b1;
            end
        end
    end

    always_comb begin
        nib        = '0;
        upper_zero = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                nib        = display[4*k +: 4];
                upper_zero = ((display >> (4*k)) == '0);
            end
        end
        seg_d = hex_to_seg(nib);
        dp_d  = 1'b0;
        if (err_flag) begin
            seg_d = blink_phase ? 7'h00 : 7'h79;
            dp_d  = !blink_phase && (idx == '0);
        end else if (i_blank_lz && (idx != '0) && upper_zero) begin
            seg_d = 7'h00;
        end
        an_d = DIGITS'(1) << idx;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            seg_q   <= '0;
            dp_q    <= 1'b0;
            an_q    <= '0;
            frame_q <= 1'b0;
        end else begin
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            frame_q <= boundary;
        end
    end

    assign o_seg   = seg_q ^ {7{INV}};
    assign o_dp    = dp_q ^ INV;
    assign o_an    = an_q ^ {DIGITS{INV}};
    assign o_frame = frame_q;

endmodule

// File: tb/tb_hex_display_scan.sv
// tb/tb_hex_display_scan.sv - randomized and directed check of hex_display_scan against a frame-level model
module tb_hex_display_scan;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] i_value = '0;
    logic        i_load = 1'b0;
    logic        i_error = 1'b0;
    logic        i_blank_lz = 1'b0;
    logic [6:0]  o_seg;
    logic        o_dp;
    logic [3:0]  o_an;
    logic        o_frame;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    hex_display_scan #(
        .DIGITS(4),
        .CLK_DIV(4),
        .BLINK_DIV(2),
        .ACTIVE_LOW(0)
    ) dut (
        .i_clock(clk),
        .i_reset_n(rst_n),
        .i_value(i_value),
        .i_load(i_load),
        .i_error(i_error),
        .i_blank_lz(i_blank_lz),
        .o_seg(o_seg),
        .o_dp(o_dp),
        .o_an(o_an),
        .o_frame(o_frame)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: position in the scan is plain arithmetic on cycles since reset.
    localparam logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int          cyc = 0;
    int          m_frames = 0;
    int          slot;
    int          dig;
    bit          phase;
    logic [15:0] m_disp = '0;
    logic [15:0] m_pend = '0;
    bit          m_pflag = 1'b0;
    bit          m_err = 1'b0;
    logic [6:0]  exp_seg = '0;
    logic        exp_dp = 1'b0;
    logic [3:0]  exp_an = '0;
    logic        exp_frame = 1'b0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            cyc = 0; m_frames = 0; m_disp = '0; m_pend = '0; m_pflag = 1'b0; m_err = 1'b0;
            exp_seg = '0; exp_dp = 1'b0; exp_an = '0; exp_frame = 1'b0;
        end else begin
            slot  = cyc % 16;
            dig   = slot / 4;
            phase = ((m_frames / 2) % 2) == 1;
            exp_an    = 4'(1 << dig);
            exp_frame = (slot == 15);
            exp_dp    = 1'b0;
            if (m_err) begin
                exp_seg = phase ? 7'h00 : 7'h79;
                exp_dp  = !phase && (dig == 0);
            end else if (i_blank_lz && dig != 0 && (m_disp >> (4*dig)) == 16'h0) begin
                exp_seg = 7'h00;
            end else begin
                exp_seg = SEG_TAB[4'(m_disp >> (4*dig))];
            end
            if (slot == 15) begin
                if (i_load) m_disp = i_value;
                else if (m_pflag) m_disp = m_pend;
                m_pflag = 1'b0;
                m_err = i_error;
                m_frames++;
            end else if (i_load) begin
                m_pend = i_value;
                m_pflag = 1'b1;
            end
            cyc++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("an", 32'(o_an), 32'(exp_an));
            chk("seg", 32'(o_seg), 32'(exp_seg));
            chk("dp", 32'(o_dp), 32'(exp_dp));
            chk("frame", 32'(o_frame), 32'(exp_frame));
        end
    end

    logic [6:0] fr_seg [4];
    logic [3:0] fr_dp;
    logic [6:0] fr_old;

    task automatic grab_frame();
        int n = 0;
        while (!o_frame && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("frame_wait", 32'(o_frame), 32'h1);
        fr_old = o_seg;
        for (int d = 0; d < 4; d++) fr_seg[d] = 'x;
        fr_dp = 'x;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                if (o_an == 4'(1 << d)) begin
                    fr_seg[d] = o_seg;
                    fr_dp[d]  = o_dp;
                end
            end
        end
    endtask

    task automatic expect_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                                input logic [6:0] s2, input logic [6:0] s3, input logic dp0);
        grab_frame();
        chk({tag, "_d0"}, 32'(fr_seg[0]), 32'(s0));
        chk({tag, "_d1"}, 32'(fr_seg[1]), 32'(s1));
        chk({tag, "_d2"}, 32'(fr_seg[2]), 32'(s2));
        chk({tag, "_d3"}, 32'(fr_seg[3]), 32'(s3));
        chk({tag, "_dp"}, 32'(fr_dp), 32'({3'b000, dp0}));
    endtask

    task automatic wait_an(input logic [3:0] target);
        int n = 0;
        while (o_an != target && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("an_wait", 32'(o_an), 32'(target));
    endtask

    task automatic pulse_load(input logic [15:0] v);
        i_value = v;
        i_load  = 1'b1;
        @(negedge clk);
        i_load  = 1'b0;
    endtask

    logic [15:0] mask;

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(o_an), 32'h0);
        chk("rst_seg", 32'(o_seg), 32'h0);
        chk("rst_frame", 32'(o_frame), 32'h0);
        #2 rst_n = 1'b1;

        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            case (k)
                1:  begin chk("scan_an0", 32'(o_an), 32'h1); chk("scan_seg0", 32'(o_seg), 32'h3F); end
                5:  chk("scan_an1", 32'(o_an), 32'h2);
                9:  chk("scan_an2", 32'(o_an), 32'h4);
                13: begin chk("scan_an3", 32'(o_an), 32'h8); chk("scan_seg3", 32'(o_seg), 32'h3F); end
                15: chk("scan_nofr", 32'(o_frame), 32'h0);
                16: chk("scan_fr1", 32'(o_frame), 32'h1);
                32: chk("scan_fr2", 32'(o_frame), 32'h1);
                default: ;
            endcase
        end

        repeat (5) @(negedge clk);
        pulse_load(16'h12AF);
        expect_frame("load", 7'h71, 7'h77, 7'h5B, 7'h06, 1'b0);
        chk("load_old", 32'(fr_old), 32'h3F);

        repeat (15) @(negedge clk);
        pulse_load(16'h8000);
        expect_frame("bnd", 7'h3F, 7'h3F, 7'h3F, 7'h7F, 1'b0);
        chk("bnd_old", 32'(fr_old), 32'h06);

        repeat (3) @(negedge clk);
        i_blank_lz = 1'b1;
        pulse_load(16'h0050);
        expect_frame("lz50", 7'h3F, 7'h6D, 7'h00, 7'h00, 1'b0);
        repeat (3) @(negedge clk);
        pulse_load(16'h0000);
        expect_frame("lz00", 7'h3F, 7'h00, 7'h00, 7'h00, 1'b0);
        i_blank_lz = 1'b0;

        wait_an(4'b0010);
        pulse_load(16'h5555);
        wait_an(4'b0100);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_an", 32'(o_an), 32'h0);
        chk("mid_rst_seg", 32'(o_seg), 32'h0);
        chk("mid_rst_dp", 32'(o_dp), 32'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        expect_frame("post_rst", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0);

        repeat (3) @(negedge clk);
        i_error = 1'b1;
        expect_frame("err_a", 7'h00, 7'h00, 7'h00, 7'h00, 1'b0);
        expect_frame("err_b", 7'h79, 7'h79, 7'h79, 7'h79, 1'b1);
        expect_frame("err_c", 7'h79, 7'h79, 7'h79, 7'h79, 1'b1);
        expect_frame("err_d", 7'h00, 7'h00, 7'h00, 7'h00, 1'b0);
        repeat (3) @(negedge clk);
        i_error = 1'b0;
        expect_frame("err_off", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0);

        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            case ($urandom_range(0, 4))
                0: mask = 16'hFFFF;
                1: mask = 16'h0FFF;
                2: mask = 16'h00FF;
                3: mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            i_value = 16'($urandom) & mask;
            i_load  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 47) == 0) i_error = ~i_error;
            if ($urandom_range(0, 15) == 0) i_blank_lz = ~i_blank_lz;
        end
        @(negedge clk);
        i_load = 1'b0;
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
